matrix_bank_dp: RTL
===================

# matrix_bank_dp

Parametrised, banked matrix storage datapath with a valid/ready request port and a backpressured response port. It holds the matrix as NUM_BANKS synchronous-read RAM banks of 2^ADDR_W words each. It serves single writes, single reads and multi-beat burst reads that walk across bank boundaries. It sits between the matrix controller, which issues requests, and the compute/readout logic, which consumes responses.

## Interface
- DATA_W, 32, matrix element width in bits
- ADDR_W, 16, per-bank word address width; bank depth is 2^ADDR_W
- NUM_BANKS, 16, number of RAM banks, range 1..256; need not be a power of two
- LEN_W, 10, burst length field width
- RSP_DEPTH, 2, response buffer entries, minimum 2
- CLK  in  1  single clock, all logic on rising edge
- RST  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted when req_valid && req_ready
- req_we  in  1  1 = write, 0 = read
- req_bank  in  BANK_W  binary bank index; BANK_W = max(1, clog2(NUM_BANKS))
- req_addr  in  ADDR_W  word address within bank
- req_len  in  LEN_W  read beats minus one; ignored for writes
- req_wdata  in  DATA_W  write data
- rsp_valid  out  1  response word available
- rsp_ready  in  1  response consumed when rsp_valid && rsp_ready
- rsp_data  out  DATA_W  read data
- rsp_last  out  1  final beat of a read request
- rsp_perr  out  1  parity error on this beat; constant 0 when parity is compiled out

## Operation
- FSM states: IDLE and BURST.
- IDLE, accepted write: writes req_wdata to bank req_bank, address req_addr, at that edge. No response. Stays in IDLE.
- IDLE, accepted read: issues beat 0 at req_bank/req_addr in the same cycle. Loads the beat counter with req_len. If req_len == 0, stays in IDLE; otherwise goes to BURST.
- BURST: issues one beat per cycle while credit is available. The read pointer advances as address + 1. At address 2^ADDR_W-1 it carries to address 0 of bank + 1. Bank NUM_BANKS-1 wraps to bank 0. After the beat with counter == 0 is issued, the FSM returns to IDLE.
- req_ready = (state == IDLE) && credit available. Writes also need credit, so ordering stays simple.
- Credit is available when (fifo_count + inflight − pop_this_cycle) < RSP_DEPTH. This sustains one beat per cycle under a continuous rsp_ready.
- A read of bank index ≥ NUM_BANKS returns all-zero data with rsp_perr = 0. A write to such a bank is dropped.
- Read data is registered by the RAM, then pushed into the RSP_DEPTH-entry response FIFO. rsp_last is carried with each beat.
- Only the addressed bank is enabled; the bank output mux is driven by a registered bank index.

## Timing
- Reset values: req_ready 0, rsp_valid 0, rsp_last 0, rsp_perr 0, state IDLE, FIFO empty, inflight 0. RAM contents are not reset.
- req_ready rises in the first cycle after RST deasserts.
- Read latency: request accepted in cycle t gives rsp_valid in cycle t+2 at the earliest. A burst of L+1 beats with rsp_ready held high completes its last beat in cycle t+2+L.
- Write then read to the same location in the next cycle returns the new data.
- rsp_valid/rsp_data/rsp_last hold stable while rsp_valid && !rsp_ready.
- Push and pop in the same cycle with the FIFO full is allowed; count is unchanged.
- RST mid-burst aborts the burst, flushes the FIFO and discards the in-flight beat. There is no response after reset.

## Configuration
- MATRIX_DP_PARITY_EN defined:
  - Each bank stores DATA_W+1 bits, the extra bit being even parity over req_wdata.
  - On read, parity is recomputed and rsp_perr = 1 on mismatch.
- Undefined: banks are DATA_W wide and rsp_perr is tied 0.

## Structure
- Package matrix_dp_pkg holds:
  - the state enum (ST_IDLE, ST_BURST)
  - the bank-width function bank_w(NUM_BANKS)
  - the parity function
- Sub-module matrix_bank_ram: a single-port RAM, WIDTH × 2^ADDR_W, with write enable, read enable and registered read output. It is instantiated NUM_BANKS times in a generate loop.
- The FSM, credit counter, response FIFO and output mux live in matrix_bank_dp.

## Test plan
- Reset, then write 0xDEADBEEF to bank 3 addr 0x0010, then read it -> rsp_data 0xDEADBEEF, rsp_last 1, rsp_valid exactly 2 cycles after read accept.
- Preload bank 0 addr 0xFFFE..0xFFFF and bank 1 addr 0..1 with 1..4. Read bank 0 addr 0xFFFE, len 3, rsp_ready high -> beats 1,2,3,4 on consecutive cycles, rsp_last only on beat 4, req_ready low during BURST.
- Preload with NUM_BANKS = 16. Read bank 15 addr 0xFFFF, len 1 -> second beat comes from bank 0 addr 0.
- Burst of 8 beats with rsp_ready toggled 1,0,0,1,... -> all 8 beats in order with none lost or duplicated, data stable while stalled, FIFO count never above RSP_DEPTH.
- Assert RST for 1 cycle mid 16-beat burst -> rsp_valid 0 the cycle after, no further beats, req_ready 1 the cycle after RST drops.
- With MATRIX_DP_PARITY_EN, force a bit flip in stored word bank 2 addr 5 -> read gives rsp_perr 1. Without the macro -> rsp_perr 0.

Source files
------------

// File: rtl/matrix_dp_pkg.sv
// matrix_dp_pkg: shared state encoding, bank-index width and parity helpers for the banked matrix datapath
package matrix_dp_pkg;

    typedef enum logic {ST_IDLE, ST_BURST} state_e;

    function automatic int bank_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic logic even_par(input logic [1023:0] v);
        return ^v;
    endfunction

endpackage

// File: rtl/matrix_bank_ram.sv
// matrix_bank_ram: single-port WIDTH x 2^ADDR_W RAM with write enable, read enable and registered read data
module matrix_bank_ram
    import matrix_dp_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 16
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [WIDTH-1:0]  wdata_i,
    output logic [WIDTH-1:0]  rdata_o
);

    logic [WIDTH-1:0] mem_q [2**ADDR_W];
    logic [WIDTH-1:0] rdata_q;

    assign rdata_o = rdata_q;

    // storage write and registered read port
    always_ff @(posedge clk_i) begin
        if (we_i) mem_q[addr_i] <= wdata_i;
        if (re_i) rdata_q <= mem_q[addr_i];
    end

endmodule

// File: rtl/matrix_bank_dp.sv
// matrix_bank_dp: banked matrix store with burst reads and credit-controlled response FIFO; MATRIX_DP_PARITY_EN adds per-word parity
module matrix_bank_dp
    import matrix_dp_pkg::*;
#(
    parameter  int DATA_W    = 32,
    parameter  int ADDR_W    = 16,
    parameter  int NUM_BANKS = 16,
    parameter  int LEN_W     = 10,
    parameter  int RSP_DEPTH = 2,
    localparam int BANK_W    = bank_w(NUM_BANKS)
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [BANK_W-1:0] req_bank,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [LEN_W-1:0]  req_len,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_last,
    output logic              rsp_perr
);

`ifdef MATRIX_DP_PARITY_EN
    localparam int RAM_W = DATA_W + 1;
`else
    localparam int RAM_W = DATA_W;
`endif
    localparam int PTR_W = $clog2(RSP_DEPTH);
    localparam int CNT_W = $clog2(RSP_DEPTH + 1);
    localparam logic [BANK_W-1:0] LAST_BANK = BANK_W'(NUM_BANKS - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
    localparam logic [PTR_W-1:0]  LAST_PTR  = PTR_W'(RSP_DEPTH - 1);

    typedef struct packed {
        logic              perr;
        logic              last;
        logic [DATA_W-1:0] data;
    } beat_t;

    state_e            state_q, state_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic [BANK_W-1:0] bank_q, bank_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              rd_vld_q, rd_last_q, rd_oob_q;
    logic [BANK_W-1:0] rd_bank_q;
    beat_t             fifo_q [RSP_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  fifo_cnt_q;

    logic              idle, credit, pop, accept, wr_en, rd_en, sel_last, sel_oob;
    logic [BANK_W-1:0] sel_bank, nxt_bank;
    logic [ADDR_W-1:0] sel_addr;
    logic [RAM_W-1:0]  ram_wdata, rd_word;
    logic [RAM_W-1:0]  ram_rdata [NUM_BANKS];
    beat_t             push_beat, head;

    assign idle      = state_q == ST_IDLE;
    assign rsp_valid = fifo_cnt_q != '0;
    assign pop       = rsp_valid && rsp_ready;
    assign credit    = ({1'b0, fifo_cnt_q} + (CNT_W+1)'(rd_vld_q) - (CNT_W+1)'(pop)) < (CNT_W+1)'(RSP_DEPTH);
    assign req_ready = !RST && idle && credit;

    // request decode, burst pointer walk and next-state selection
    always_comb begin
        accept   = req_valid && req_ready;
        wr_en    = accept && req_we;
        rd_en    = idle ? accept && !req_we : credit;
        sel_bank = idle ? req_bank : bank_q;
        sel_addr = idle ? req_addr : addr_q;
        sel_last = idle ? req_len == '0 : cnt_q == '0;
        sel_oob  = {1'b0, sel_bank} >= (BANK_W+1)'(NUM_BANKS);
        nxt_bank = (sel_addr != LAST_ADDR) ? sel_bank : (sel_bank == LAST_BANK) ? '0 : sel_bank + 1'b1;
        state_d  = rd_en ? (sel_last ? ST_IDLE : ST_BURST) : state_q;
        cnt_d    = rd_en ? (idle ? req_len : cnt_q) - 1'b1 : cnt_q;
        bank_d   = rd_en ? nxt_bank : bank_q;
        addr_d   = rd_en ? sel_addr + 1'b1 : addr_q;
    end

`ifdef MATRIX_DP_PARITY_EN
    assign ram_wdata = {even_par(1024'(req_wdata)), req_wdata};
`else
    assign ram_wdata = req_wdata;
`endif

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        matrix_bank_ram #(.WIDTH(RAM_W), .ADDR_W(ADDR_W)) u_ram (
            .clk_i   (CLK),
            .we_i    (wr_en && sel_bank == BANK_W'(b)),
            .re_i    (rd_en && sel_bank == BANK_W'(b)),
            .addr_i  (sel_addr),
            .wdata_i (ram_wdata),
            .rdata_o (ram_rdata[b])
        );
    end

    assign rd_word = ram_rdata[rd_bank_q];

    // shape the registered RAM word into a response beat; out-of-range banks read as zero
    always_comb begin
        push_beat.data = rd_oob_q ? '0 : rd_word[DATA_W-1:0];
        push_beat.last = rd_last_q;
`ifdef MATRIX_DP_PARITY_EN
        push_beat.perr = !rd_oob_q && (even_par(1024'(rd_word[DATA_W-1:0])) != rd_word[DATA_W]);
`else
        push_beat.perr = 1'b0;
`endif
    end

    // control state and in-flight flag; reset aborts any burst and drops the pending beat
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= ST_IDLE;
            rd_vld_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            rd_vld_q <= rd_en;
        end
    end

    // burst pointer, beat counter and tags travelling alongside the RAM read
    always_ff @(posedge CLK) begin
        cnt_q     <= cnt_d;
        bank_q    <= bank_d;
        addr_q    <= addr_d;
        rd_bank_q <= sel_bank;
        rd_last_q <= sel_last;
        rd_oob_q  <= sel_oob;
    end

    // response FIFO pointers and occupancy; credit guarantees a push never overflows
    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
        end else begin
            wr_ptr_q   <= rd_vld_q ? ((wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1) : wr_ptr_q;
            rd_ptr_q   <= pop ? ((rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1) : rd_ptr_q;
            fifo_cnt_q <= fifo_cnt_q + CNT_W'(rd_vld_q) - CNT_W'(pop);
        end
    end

    // response FIFO storage
    always_ff @(posedge CLK) begin
        if (rd_vld_q) fifo_q[wr_ptr_q] <= push_beat;
    end

    assign head     = fifo_q[rd_ptr_q];
    assign rsp_data = head.data;
    assign rsp_last = rsp_valid && head.last;
    assign rsp_perr = rsp_valid && head.perr;

endmodule
